// File: rtl/ecc_secded_enc64.sv
// ecc_secded_enc64
// SEC-DED (72,64) extended-Hamming encoder for the cache data write path.
// The 64 data bits pass straight through and 8 check bits are appended:
//   OUT[63:0]  = IN
//   OUT[70:64] = C6..C0, Hamming check bits over the data positions
//   OUT[71]    = C7, overall parity, so every codeword has even weight
// Data bit i sits at Hamming position p(i). p(i) is the i-th integer in 3..71,
// counting upwards and skipping the powers of two, which are the check-bit
// positions. Check bit Cj covers every data bit whose position has bit j set.
//
// Handshake: this block has none. A new word may be presented every cycle.
// With REGISTER_OUT=0 the codeword follows IN combinationally.
// With REGISTER_OUT=1 the codeword is the encoding of IN as sampled at the
// previous rising clk edge. A reset edge loads the all-zero codeword, which is
// itself a valid codeword.
module ecc_secded_enc64 #(
  parameter bit REGISTER_OUT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] IN,
  output logic [71:0] OUT
);

  // Hamming position of each data bit. This is resolved at elaboration time.
  function automatic logic [63:0][6:0] build_pos_map();
    logic [63:0][6:0] map;
    int unsigned      idx;
    map = '0;
    idx = 0;
    for (int unsigned p = 3; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        map[idx[5:0]] = p[6:0];
        idx++;
      end
    end
    return map;
  endfunction

  localparam logic [63:0][6:0] POS_MAP = build_pos_map();

  // One 64-bit coverage mask per Hamming check bit.
  // Bit i of mask j is set when data bit i contributes to Cj.
  function automatic logic [6:0][63:0] build_chk_masks();
    logic [6:0][63:0] m;
    m = '0;
    for (int j = 0; j < 7; j++) begin
      for (int i = 0; i < 64; i++) begin
        m[j][i] = POS_MAP[i][j];
      end
    end
    return m;
  endfunction

  localparam logic [6:0][63:0] CHK_MASK = build_chk_masks();

  logic [6:0]  chk_lo;
  logic        chk_par;
  logic [71:0] code_word;

  // Check bits are computed as parity trees over the masked data.
  // C7 folds in both the data and C0..C6, giving the codeword even weight.
  always_comb begin
    chk_lo = '0;
    for (int j = 0; j < 7; j++) begin
      chk_lo[j] = ^(IN & CHK_MASK[j]);
    end
    chk_par   = (^IN) ^ (^chk_lo);
    code_word = {chk_par, chk_lo, IN};
  end

  generate
    if (REGISTER_OUT) begin : g_reg
      logic [71:0] out_q;
      logic [71:0] out_d;

      // The next-state value is always the fresh encoding.
      // Reset overrides it inside the register.
      always_comb begin
        out_d = code_word;
      end

      // Output register. Reset takes priority over a new word on the same edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q <= '0;
        end else begin
          out_q <= out_d;
        end
      end

      assign OUT = out_q;
    end else begin : g_comb
      // clk and rst are intentionally ignored in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign OUT = code_word;
    end
  endgenerate

endmodule

// File: tb/tb_ecc_secded_enc64.sv
// tb_ecc_secded_enc64
// Testbench covering both builds side by side.
// dut0 is the combinational build and dut1 is the registered build.
// Both instances share the same clk, rst and IN stimulus.
module tb_ecc_secded_enc64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_w = '0;
  logic [71:0] out0;
  logic [71:0] out1;

  logic        drv_vld = 1'b0;  // a comb-build response is due at this negedge
  logic        vld1_q  = 1'b0;  // a registered-build response is due at this negedge

  logic [71:0] exp0_q[$];
  logic [71:0] exp1_q[$];

  int num_checks = 0;
  int num_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ecc_secded_enc64 #(.REGISTER_OUT(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .IN  (in_w),
    .OUT (out0)
  );

  ecc_secded_enc64 #(.REGISTER_OUT(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .IN  (in_w),
    .OUT (out1)
  );

  // ---------------- reference model ----------------
  // The Hamming syndrome of a word is the XOR of the positions of its set data bits.
  // C7 is the parity of the data bits together with that syndrome.
  function automatic logic [7:0] ref_check(input logic [63:0] d);
    logic [6:0]  syn;
    int unsigned pos;
    syn = '0;
    pos = 3;
    for (int i = 0; i < 64; i++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      if (d[i]) syn = syn ^ pos[6:0];
      pos++;
    end
    return {(^d) ^ (^syn), syn};
  endfunction

  // ---------------- driver tasks ----------------
  // Drive a word whose check byte is supplied by the caller.
  // The combinational build must ignore r.
  // The registered build shows zero when r is high at the sampling edge.
  task automatic drive_chk(input logic [63:0] d, input logic [7:0] chk, input logic r);
    @(posedge clk);
    #1;
    in_w    = d;
    rst     = r;
    drv_vld = 1'b1;
    exp0_q.push_back({chk, d});
    exp1_q.push_back(r ? 72'h0 : {chk, d});
  endtask

  // Drive a word whose check byte comes from the reference model.
  task automatic drive(input logic [63:0] d, input logic r);
    drive_chk(d, ref_check(d), r);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    drv_vld = 1'b0;
    rst     = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  // Delay the valid flag by one stage to track the registered build's latency.
  always @(posedge clk) vld1_q <= drv_vld;

  // Compare both outputs at the negedge, away from the active clock edge.
  always @(negedge clk) begin
    logic [71:0] e;
    if (drv_vld) begin
      num_checks++;
      if (exp0_q.size() == 0) begin
        num_errors++;
        $display("FAIL comb_queue: response with no expected entry, got %h", out0);
      end else begin
        e = exp0_q.pop_front();
        if (out0 !== e) begin
          num_errors++;
          $display("FAIL comb_out: got %h required %h", out0, e);
        end
      end
      num_checks++;
      if (($countones(out0) % 2) != 0) begin
        num_errors++;
        $display("FAIL comb_even_weight: got %h (odd popcount) required even", out0);
      end
    end
    if (vld1_q) begin
      num_checks++;
      if (exp1_q.size() == 0) begin
        num_errors++;
        $display("FAIL reg_queue: response with no expected entry, got %h", out1);
      end else begin
        e = exp1_q.pop_front();
        if (out1 !== e) begin
          num_errors++;
          $display("FAIL reg_out: got %h required %h", out1, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] a;
    logic [63:0] b;

    // Reset with IN=1.
    // The registered build reads zero.
    // The combinational build already shows {83,1}.
    drive_chk(64'h1, 8'h83, 1'b1);
    drive_chk(64'h1, 8'h83, 1'b0);

    // Directed vectors with hand-computed check bytes.
    // Reset is toggled to show the combinational build ignores it.
    drive_chk(64'h2,                  8'h85, 1'b0);
    drive_chk(64'h8,                  8'h07, 1'b1);
    drive_chk(64'h8,                  8'h07, 1'b0);
    drive_chk(64'h8,                  8'h07, 1'b1);
    drive_chk(64'h4,                  8'h86, 1'b0);
    drive_chk(64'h10,                 8'h89, 1'b0);
    drive_chk(64'h8000_0000_0000_0000, 8'hC7, 1'b0);
    drive_chk(64'h0,                  8'h00, 1'b0);
    drive_chk(64'h9,                  8'h84, 1'b0);

    // Reset on the same edge as a new word: reset wins.
    // The word after it loads normally.
    drive_chk(64'hDEAD_BEEF_0000_0001, ref_check(64'hDEAD_BEEF_0000_0001), 1'b1);
    drive_chk(64'h1, 8'h83, 1'b0);

    // Walking one through all 64 data bits, then zero.
    for (int i = 0; i < 64; i++) begin
      a = 64'h1 << i;
      drive(a, 1'b0);
    end
    drive_chk(64'h0, 8'h00, 1'b0);

    // Linearity on fixed pairs: check(A^B) == check(A) ^ check(B).
    for (int k = 0; k < 6; k++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      drive_chk(a ^ b, ref_check(a) ^ ref_check(b), 1'b0);
    end

    // Background words, with an occasional reset.
    for (int k = 0; k < 200; k++) begin
      a = {$urandom(), $urandom()};
      drive(a, ($urandom_range(0, 15) == 0));
    end

    idle();
    repeat (3) @(posedge clk);
    #1;

    num_checks++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      num_errors++;
      $display("FAIL drain: pending comb=%0d reg=%0d required 0", exp0_q.size(), exp1_q.size());
    end

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

endmodule
